// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: drives an external 1-bit full-adder slice
// LSB first and assembles the result, carry-out and signed overflow.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             x_bit,
  output logic             y_bit,
  output logic             c_in_bit,
  output logic [3:0]       c_en,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sum;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_op;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;
  logic             w_step;
  logic [WIDTH-1:0] w_sum_full;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last     = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_step     = (r_state == RUN) && !abort;
  // r_sum holds the WIDTH-1 sums already produced; the current sum completes the word
  assign w_sum_full = {sum_bit, r_sum};

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    x_bit    = 1'b0;
    y_bit    = 1'b0;
    c_in_bit = 1'b0;
    c_en     = 4'b0001;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = LOAD;
      end
      LOAD: begin
        busy   = 1'b1;
        w_next = abort ? IDLE : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        c_en     = 4'b0010;
        x_bit    = r_a[0];
        y_bit    = r_b[0];
        c_in_bit = r_carry;
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = FIN;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_op     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry with op
      r_a     <= a;
      r_b     <= op ? ~b : b;
      r_op    <= op;
      r_carry <= op;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= (WIDTH-1)'(w_sum_full >> 1);
      r_carry <= carry_bit;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_sum_full;
        r_cout   <= carry_bit;
        r_ovf    <= (r_a_msb == (r_b_msb ^ r_op)) && (sum_bit != r_a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with an ideal full-adder slice model.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, op, abort;
  logic [31:0] a_i, b_i;
  logic        x_bit, y_bit, c_in_bit, sum_bit, carry_bit;
  logic [3:0]  c_en;
  logic        busy, done, cout, ovf;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sum_bit   = x_bit ^ y_bit ^ c_in_bit;
  assign carry_bit = (x_bit & y_bit) | (x_bit & c_in_bit) | (y_bit & c_in_bit);

  serial_add_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a_i), .b(b_i), .abort(abort),
    .x_bit(x_bit), .y_bit(y_bit), .c_in_bit(c_in_bit), .c_en(c_en),
    .sum_bit(sum_bit), .carry_bit(carry_bit), .busy(busy), .done(done),
    .result(result), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and follows it to done (bounded).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                        output logic [31:0] r_res, output logic r_co, output logic r_ov,
                        output int lat, output int cen_run, output int cen_bad,
                        output logic [31:0] xs);
    int p;
    int k;
    a_i = ta; b_i = tb_v; op = top; start = 1'b1;
    p = 0; k = 0; lat = -1; cen_run = 0; cen_bad = 0; xs = '0;
    r_res = '0; r_co = 1'b0; r_ov = 1'b0;
    while (lat < 0 && p < 100) begin
      step();
      p++;
      start = 1'b0;
      if (c_en == 4'b0010) begin
        cen_run++;
        if (k < 32) xs[k] = x_bit;
        k++;
      end else if (c_en != 4'b0001 || x_bit || y_bit || c_in_bit) begin
        cen_bad++;
      end
      if (done) begin
        lat = p; r_res = result; r_co = cout; r_ov = ovf;
      end
    end
  endtask

  initial begin
    logic [31:0] g_res, g_xs, prev;
    logic        g_co, g_ov;
    int          g_lat, g_run, g_bad, dones;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    tbl[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0; a_i = '0; b_i = '0;
    step(); step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_cen", 64'(c_en), 64'h1);
    chk("rst_xbit", 64'({x_bit, y_bit, c_in_bit}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, g_res, g_co, g_ov, g_lat, g_run, g_bad, g_xs);
      chk($sformatf("v%0d_latency", i), 64'(g_lat), 64'd34);
      chk($sformatf("v%0d_result", i), 64'(g_res), 64'(tbl[i].res));
      chk($sformatf("v%0d_cout", i), 64'(g_co), 64'(tbl[i].co));
      chk($sformatf("v%0d_ovf", i), 64'(g_ov), 64'(tbl[i].ov));
      chk($sformatf("v%0d_cen_run", i), 64'(g_run), 64'd32);
      chk($sformatf("v%0d_cen_other", i), 64'(g_bad), 64'd0);
      chk($sformatf("v%0d_xbits", i), 64'(g_xs), 64'(tbl[i].a));
      step();
    end

    // Abort at RUN bit 10 (period 12 after acceptance)
    prev = tbl[8].res;
    a_i = 32'h1111_1111; b_i = 32'h2222_2222; op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 2; p <= 12; p++) step();
    chk("abort_in_run", 64'(c_en), 64'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result_kept", 64'(result), 64'(prev));
    dones = 0;
    for (int p = 0; p < 40; p++) begin
      if (done) dones++;
      step();
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op(32'h1111_1111, 32'h2222_2222, 1'b0, g_res, g_co, g_ov, g_lat, g_run, g_bad, g_xs);
    chk("post_abort_latency", 64'(g_lat), 64'd34);
    chk("post_abort_result", 64'(g_res), 64'h3333_3333);
    step();

    // Reset at RUN bit 7 (period 9)
    a_i = 32'hDEAD_BEEF; b_i = 32'h0000_1234; op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 2; p <= 9; p++) step();
    rst = 1'b1;
    step();
    chk("mrst_result", 64'(result), 64'd0);
    chk("mrst_flags", 64'({cout, ovf, busy, done}), 64'd0);
    chk("mrst_slice", 64'({x_bit, y_bit, c_in_bit}), 64'd0);
    chk("mrst_cen", 64'(c_en), 64'h1);
    rst = 1'b0;
    run_op(32'h0000_000A, 32'h0000_0004, 1'b1, g_res, g_co, g_ov, g_lat, g_run, g_bad, g_xs);
    chk("post_rst_latency", 64'(g_lat), 64'd34);
    chk("post_rst_result", 64'(g_res), 64'h6);
    chk("post_rst_cout", 64'(g_co), 64'd1);
    step();

    // Start held high through RUN, the final bit and FIN: one operation only
    a_i = 32'h0000_0100; b_i = 32'h0000_00FF; op = 1'b0; start = 1'b1;
    dones = 0;
    for (int p = 1; p <= 35; p++) begin
      step();
      if (done) begin
        dones++;
        chk("busy_start_result", 64'(result), 64'h1FF);
      end
    end
    start = 1'b0;
    for (int p = 0; p < 40; p++) begin
      step();
      if (done) dones++;
    end
    chk("busy_start_dones", 64'(dones), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port op, input, 1, operation select: 0 = add, 1 = subtract (a - b).
REQ-006 SHALL have ports a and b, input, WIDTH each, the operands, sampled only on an accepted start.
REQ-007 SHALL have port abort, input, 1, cancels an operation in progress.
REQ-008 SHALL have ports x_bit and y_bit, output, 1 each, operand bits driven to the 1-bit slice.
REQ-009 SHALL have port c_in_bit, output, 1, carry driven into the slice.
REQ-010 SHALL have port c_en, output, 4, slice carry-enable control.
REQ-011 SHALL have ports sum_bit and carry_bit, input, 1 each, combinational results returned from the slice.
REQ-012 SHALL have port busy, output, 1, high from acceptance through the cycle before done.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have ports result (WIDTH), cout (1) and ovf (1), outputs, valid while done is high and held until the next accepted start.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, RUN and FIN.
REQ-016 SHALL accept start only in IDLE: IDLE->LOAD; in LOAD, latch a into shift register A, latch b (bitwise inverted when op=1) into shift register B, latch op, and set the carry register to op.
REQ-017 SHALL move LOAD->RUN after exactly one cycle.
REQ-018 SHALL, in RUN, process one bit per cycle, LSB first, with bit counter 0..WIDTH-1: x_bit=A[0], y_bit=B[0], c_in_bit=carry register.
REQ-019 SHALL, each RUN cycle, shift sum_bit into the result register MSB with a right shift, load carry_bit into the carry register, and shift A and B right by one.
REQ-020 SHALL move RUN->FIN when the counter equals WIDTH-1 (after the last bit is consumed); FIN->IDLE unconditionally after one cycle.
REQ-021 SHALL hold done high only in FIN, with cout = final carry register and ovf = (a[MSB]==B_eff[MSB]) && (result[MSB]!=a[MSB]), where B_eff is b for op=0 and ~b for op=1.
REQ-022 SHALL give a latency of WIDTH+2 cycles from the cycle start is sampled to the cycle done is high.
REQ-023 SHALL drive c_en=4'b0010 in RUN and c_en=4'b0001 (carry suppressed) in all other states.
REQ-024 SHALL drive x_bit, y_bit and c_in_bit to 0 outside RUN.
REQ-025 SHALL ignore start while busy or done is high; no queueing.
REQ-026 SHALL, when abort is high in LOAD or RUN, go to IDLE next cycle without asserting done, leave result/cout/ovf at their previous values, and let abort take priority over start in the same cycle.
REQ-027 SHALL, when start and the final RUN bit coincide, finish the current operation and ignore the start.
REQ-028 SHALL compute subtraction in two's complement: cout=1 means no borrow (a>=b unsigned).

Reset
REQ-029 SHALL, on rst, set state=IDLE, counter=0, A=B=result=0, carry=0, busy=0, done=0, cout=0 and ovf=0.
REQ-030 SHALL give rst priority over abort and start, including mid-RUN; the first start is accepted the cycle after rst deasserts.

Verification (bench models the slice as an ideal full adder: sum=x^y^c, carry=maj(x,y,c))
REQ-031 SHALL verify add: WIDTH=32, a=0x0000_0005, b=0x0000_0003, op=0 -> done at cycle 34, result=0x8, cout=0, ovf=0.
REQ-032 SHALL verify wrap and overflow: a=0x7FFF_FFFF, b=1, op=0 -> result=0x8000_0000, cout=0, ovf=1; a=0xFFFF_FFFF, b=1 -> result=0, cout=1, ovf=0.
REQ-033 SHALL verify subtract: a=3, b=5, op=1 -> result=0xFFFF_FFFE, cout=0; a=5, b=5 -> result=0, cout=1.
REQ-034 SHALL verify abort: assert abort at RUN bit 10 -> no done, busy low next cycle, result retains prior value; next start completes normally.
REQ-035 SHALL verify mid-RUN reset and start-while-busy: rst at bit 7 -> all outputs zero next cycle; start pulses during RUN -> exactly one done pulse.
REQ-036 SHALL verify the slice controls: c_en=0010 for exactly WIDTH consecutive cycles per operation, 0001 otherwise; x_bit sequence equals a LSB-first.
